// File: rtl/inst_fetch_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_pkg
// Brief    : Shared types and constants for the instruction-fetch responder.
// Revision : 1.0 - initial release
// ============================================================================
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } fetch_state_e;

    localparam logic [1:0]  ERR_OK             = 2'b00;
    localparam logic [1:0]  ERR_MISALIGN       = 2'b01;
    localparam logic [1:0]  ERR_RANGE          = 2'b10;
    localparam logic [31:0] c_NOP_WORD_DEFAULT = 32'h0000_0000;

    // Misalignment outranks an out-of-range address.
    function automatic logic [1:0] fetch_err(input logic misalign, input logic out_of_range);
        if (misalign) begin
            return ERR_MISALIGN;
        end else if (out_of_range) begin
            return ERR_RANGE;
        end
        return ERR_OK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_responder_if
// Brief    : Fetch request/response handshake plus boot-time load port.
// Revision : 1.0 - initial release
// ============================================================================
interface inst_fetch_responder_if #(
    parameter int DEPTH_WORDS = 64
);
    localparam int c_AW = $clog2(DEPTH_WORDS);

    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_addr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_data;
    logic [1:0]      rsp_err;
    logic            ld_en;
    logic [c_AW-1:0] ld_addr;
    logic [31:0]     ld_data;
    logic            busy;

    modport master (
        output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy
    );

endinterface
`default_nettype wire

// File: rtl/inst_fetch_responder_mem.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem_array
// Brief    : DEPTH_WORDS x 32 storage, synchronous write, combinational read.
// Revision : 1.0 - initial release
// ============================================================================
module inst_mem_array #(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [31:0]       i_wdata,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/inst_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_responder
// Brief    : Ready/valid instruction-fetch responder with fixed read latency.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_responder
    import inst_fetch_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter int          READ_LAT    = 1,
    parameter logic [31:0] NOP_WORD    = c_NOP_WORD_DEFAULT
) (
    input  wire logic             clk,
    input  wire logic             rst,
    inst_fetch_responder_if.slave bus
);

    localparam int         c_AW        = $clog2(DEPTH_WORDS);
    localparam logic [1:0] c_WAIT_LAST = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [1:0]      r_cnt;
    logic [1:0]      w_cnt_nxt;
    logic [31:0]     r_rsp_data;
    logic [1:0]      r_rsp_err;
    logic            w_req_ready;
    logic            w_accept;
    logic            w_misalign;
    logic            w_out_of_range;
    logic [1:0]      w_err;
    logic [c_AW-1:0] w_word_idx;
    logic [31:0]     w_mem_rdata;
    logic            w_ld_we;

    assign w_misalign     = |bus.req_addr[1:0];
    assign w_out_of_range = |bus.req_addr[31:c_AW+2];
    assign w_word_idx     = bus.req_addr[c_AW+1:2];
    assign w_err          = fetch_err(w_misalign, w_out_of_range);

    // Loads and requests are both ignored while reset is held.
    assign w_ld_we = bus.ld_en & rst;

    inst_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (c_AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_ld_we),
        .i_waddr (bus.ld_addr),
        .i_wdata (bus.ld_data),
        .i_raddr (w_word_idx),
        .o_rdata (w_mem_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_ready = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = rst & ~bus.ld_en;
                w_accept    = w_req_ready & bus.req_valid;
                if (w_accept) begin
                    w_cnt_nxt = 2'd0;
                    if (READ_LAT == 1) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == c_WAIT_LAST) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Response is snapshotted at accept so later loads cannot disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_data <= 32'h0000_0000;
            r_rsp_err  <= ERR_OK;
        end else if (w_accept) begin
            r_rsp_data <= (w_err == ERR_OK) ? w_mem_rdata : NOP_WORD;
            r_rsp_err  <= w_err;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_responder
// Brief    : Directed self-checking bench, READ_LAT=1 and READ_LAT=3 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_responder;
    import inst_fetch_pkg::*;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // index 0 -> READ_LAT=1 instance, index 1 -> READ_LAT=3 instance
    logic        vld    [2];
    logic [31:0] addr   [2];
    logic        rrdy   [2];
    logic        lden   [2];
    logic [5:0]  ldaddr [2];
    logic [31:0] lddata [2];
    logic        rdy_o  [2];
    logic        rv_o   [2];
    logic        busy_o [2];
    logic [31:0] rd_o   [2];
    logic [1:0]  er_o   [2];

    inst_fetch_responder_if #(.DEPTH_WORDS(64)) bus_l1 ();
    inst_fetch_responder_if #(.DEPTH_WORDS(64)) bus_l3 ();

    assign bus_l1.req_valid = vld[0];
    assign bus_l1.req_addr  = addr[0];
    assign bus_l1.rsp_ready = rrdy[0];
    assign bus_l1.ld_en     = lden[0];
    assign bus_l1.ld_addr   = ldaddr[0];
    assign bus_l1.ld_data   = lddata[0];
    assign rdy_o[0]  = bus_l1.req_ready;
    assign rv_o[0]   = bus_l1.rsp_valid;
    assign busy_o[0] = bus_l1.busy;
    assign rd_o[0]   = bus_l1.rsp_data;
    assign er_o[0]   = bus_l1.rsp_err;

    assign bus_l3.req_valid = vld[1];
    assign bus_l3.req_addr  = addr[1];
    assign bus_l3.rsp_ready = rrdy[1];
    assign bus_l3.ld_en     = lden[1];
    assign bus_l3.ld_addr   = ldaddr[1];
    assign bus_l3.ld_data   = lddata[1];
    assign rdy_o[1]  = bus_l3.req_ready;
    assign rv_o[1]   = bus_l3.rsp_valid;
    assign busy_o[1] = bus_l3.busy;
    assign rd_o[1]   = bus_l3.rsp_data;
    assign er_o[1]   = bus_l3.rsp_err;

    inst_fetch_responder #(.DEPTH_WORDS(64), .READ_LAT(1), .NOP_WORD(c_NOP)) u_dut_l1 (
        .clk (clk),
        .rst (rst),
        .bus (bus_l1)
    );

    inst_fetch_responder #(.DEPTH_WORDS(64), .READ_LAT(3), .NOP_WORD(c_NOP)) u_dut_l3 (
        .clk (clk),
        .rst (rst),
        .bus (bus_l3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic load_both(input logic [5:0] idx, input logic [31:0] w);
        for (int d = 0; d < 2; d++) begin
            lden[d] = 1'b1; ldaddr[d] = idx; lddata[d] = w;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) lden[d] = 1'b0;
    endtask

    task automatic do_fetch(input int d, input logic [31:0] a, output logic [31:0] data,
                            output logic [1:0] err, output int lat, output int acc_cyc);
        int guard;
        vld[d] = 1'b1; addr[d] = a; rrdy[d] = 1'b1;
        #1;
        guard = 0;
        while (!rdy_o[d] && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        if (!rdy_o[d]) check("accept_timeout", 32'(rdy_o[d]), 32'd1);
        acc_cyc = cyc;
        @(negedge clk);
        vld[d] = 1'b0;
        #1;
        lat = 1;
        while (!rv_o[d] && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        if (!rv_o[d]) check("rsp_timeout", 32'(rv_o[d]), 32'd1);
        data = rd_o[d];
        err  = er_o[d];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] prog [4];
        logic [31:0] data;
        logic [1:0]  err;
        int          lat;
        int          acc;
        int          prev_acc;

        prog[0] = 32'h2002_0005; prog[1] = 32'h0800_0004;
        prog[2] = 32'h1000_0002; prog[3] = 32'hAC01_0000;
        prev_acc = 0;
        for (int d = 0; d < 2; d++) begin
            vld[d] = 1'b0; addr[d] = '0; rrdy[d] = 1'b0;
            lden[d] = 1'b0; ldaddr[d] = '0; lddata[d] = '0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_rsp_valid", 32'(rv_o[d]), 32'd0);
            check("rst_req_ready", 32'(rdy_o[d]), 32'd0);
            check("rst_busy", 32'(busy_o[d]), 32'd0);
            check("rst_rsp_data", rd_o[d], 32'd0);
            check("rst_rsp_err", 32'(er_o[d]), 32'(ERR_OK));
        end
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 4; i++) load_both(6'(i), prog[i]);

        // READ_LAT=1 back-to-back fetches
        for (int i = 0; i < 4; i++) begin
            do_fetch(0, 32'(i * 4), data, err, lat, acc);
            check("l1_data", data, prog[i]);
            check("l1_err", 32'(err), 32'(ERR_OK));
            check("l1_latency", 32'(lat), 32'd1);
            if (i > 0) check("l1_accept_spacing", 32'(acc - prev_acc), 32'd2);
            prev_acc = acc;
        end

        // READ_LAT=3 with consumer stalled
        vld[1] = 1'b1; addr[1] = 32'h4; rrdy[1] = 1'b0;
        #1;
        check("l3_ready_idle", 32'(rdy_o[1]), 32'd1);
        @(negedge clk);
        vld[1] = 1'b0;
        #1;
        check("l3_ready_wait", 32'(rdy_o[1]), 32'd0);
        check("l3_busy_wait", 32'(busy_o[1]), 32'd1);
        check("l3_valid_a1", 32'(rv_o[1]), 32'd0);
        @(negedge clk); #1;
        check("l3_valid_a2", 32'(rv_o[1]), 32'd0);
        @(negedge clk); #1;
        check("l3_valid_a3", 32'(rv_o[1]), 32'd1);
        check("l3_data", rd_o[1], 32'h0800_0004);
        check("l3_err", 32'(er_o[1]), 32'(ERR_OK));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check("l3_hold_valid", 32'(rv_o[1]), 32'd1);
            check("l3_hold_data", rd_o[1], 32'h0800_0004);
            check("l3_hold_ready", 32'(rdy_o[1]), 32'd0);
        end
        rrdy[1] = 1'b1;
        #1;
        check("l3_ready_in_resp", 32'(rdy_o[1]), 32'd0);
        @(negedge clk); #1;
        check("l3_valid_drop", 32'(rv_o[1]), 32'd0);
        check("l3_ready_back", 32'(rdy_o[1]), 32'd1);
        check("l3_busy_back", 32'(busy_o[1]), 32'd0);

        // Error decode
        do_fetch(0, 32'h6, data, err, lat, acc);
        check("misalign_err", 32'(err), 32'(ERR_MISALIGN));
        check("misalign_data", data, c_NOP);
        do_fetch(0, 32'h100, data, err, lat, acc);
        check("range_err", 32'(err), 32'(ERR_RANGE));
        check("range_data", data, c_NOP);
        do_fetch(0, 32'h102, data, err, lat, acc);
        check("priority_err", 32'(err), 32'(ERR_MISALIGN));
        check("priority_data", data, c_NOP);

        // Load collides with request in IDLE
        @(negedge clk);
        vld[0] = 1'b1; addr[0] = 32'h10;
        lden[0] = 1'b1; ldaddr[0] = 6'd4; lddata[0] = 32'hDEAD_BEEF;
        #1;
        check("collide_ready", 32'(rdy_o[0]), 32'd0);
        check("collide_busy", 32'(busy_o[0]), 32'd0);
        @(negedge clk);
        lden[0] = 1'b0;
        #1;
        check("collide_not_accepted", 32'(rv_o[0]), 32'd0);
        check("collide_ready_next", 32'(rdy_o[0]), 32'd1);
        @(negedge clk);
        vld[0] = 1'b0;
        #1;
        check("collide_valid", 32'(rv_o[0]), 32'd1);
        check("collide_data", rd_o[0], 32'hDEAD_BEEF);

        // Snapshot: load during WAIT does not alter in-flight response
        vld[1] = 1'b1; addr[1] = 32'h8; rrdy[1] = 1'b1;
        #1;
        check("snap_ready", 32'(rdy_o[1]), 32'd1);
        @(negedge clk);
        vld[1] = 1'b0;
        lden[1] = 1'b1; ldaddr[1] = 6'd2; lddata[1] = 32'hFFFF_FFFF;
        @(negedge clk);
        lden[1] = 1'b0;
        #1;
        check("snap_valid_a2", 32'(rv_o[1]), 32'd0);
        @(negedge clk); #1;
        check("snap_valid_a3", 32'(rv_o[1]), 32'd1);
        check("snap_old_data", rd_o[1], 32'h1000_0002);
        do_fetch(1, 32'h8, data, err, lat, acc);
        check("snap_new_data", data, 32'hFFFF_FFFF);
        check("snap_new_latency", 32'(lat), 32'd3);

        // Reset during WAIT
        @(negedge clk);
        vld[1] = 1'b1; addr[1] = 32'h4;
        #1;
        check("rstw_ready", 32'(rdy_o[1]), 32'd1);
        @(negedge clk);
        vld[1] = 1'b0;
        #1;
        check("rstw_busy_before", 32'(busy_o[1]), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rstw_valid", 32'(rv_o[1]), 32'd0);
        check("rstw_busy", 32'(busy_o[1]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            check("rstw_no_stale", 32'(rv_o[1]), 32'd0);
        end
        do_fetch(1, 32'h0, data, err, lat, acc);
        check("rstw_retained", data, 32'h2002_0005);
        check("rstw_err", 32'(err), 32'(ERR_OK));
        check("rstw_latency", 32'(lat), 32'd3);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
